// File: rtl/reg_swap_ctrl.sv
// Register-transfer controller: NREG x WIDTH register file plus a temp register on a
// shared bus, running SWAP (via temp) or COPY. Optional op counter: REG_SWAP_CNT_EN.
module reg_swap_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int SELW  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w,
  input  logic             mode,
  input  logic [SELW-1:0]  sel_a,
  input  logic [SELW-1:0]  sel_b,
  input  logic             ld,
  input  logic [SELW-1:0]  ld_sel,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SELW-1:0]  rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic [NREG:0]    rout,
  output logic [NREG:0]    rin,
  output logic [WIDTH-1:0] bus,
  output logic             busy,
  output logic             Done,
`ifdef REG_SWAP_CNT_EN
  output logic [15:0]      op_cnt,
`endif
  output logic             err
);

  localparam int IDXW = $clog2(NREG + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    CP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [SELW-1:0]       a_q, a_d, b_q, b_d;
  logic                  err_q, err_d;
  logic [WIDTH-1:0]      regs_q [NREG+1];
  logic                  ld_en_s;
  logic                  a_bad_s, b_bad_s, ld_bad_s;
  logic                  drv_vld_s, cap_vld_s, done_s;
  logic [IDXW-1:0]       drv_idx_s, cap_idx_s;
  logic [NREG:0]         rout_s, rin_s;
  logic [WIDTH-1:0]      bus_s;

  assign a_bad_s  = (int'(sel_a)  >= NREG);
  assign b_bad_s  = (int'(sel_b)  >= NREG);
  assign ld_bad_s = (int'(ld_sel) >= NREG);

  // State, captured operands and error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= {SELW{1'b0}};
      b_q     <= {SELW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
    end
  end

  // Next-state: command acceptance in IDLE, fixed sequencing elsewhere; w beats ld
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = 1'b0;
    ld_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (w) begin
          if (a_bad_s || b_bad_s) begin
            err_d = 1'b1;
          end else begin
            a_d     = sel_a;
            b_d     = sel_b;
            state_d = mode ? CP : S1;
          end
        end else if (ld) begin
          if (ld_bad_s) begin
            err_d = 1'b1;
          end else begin
            ld_en_s = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      S1:      state_d = S2;
      S2:      state_d = S3;
      S3:      state_d = IDLE;
      CP:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore decode of bus driver / capture indices from the state
  always_comb begin
    drv_vld_s = 1'b0;
    cap_vld_s = 1'b0;
    drv_idx_s = {IDXW{1'b0}};
    cap_idx_s = {IDXW{1'b0}};
    done_s    = 1'b0;
    case (state_q)
      S1: begin
        drv_vld_s = 1'b1; drv_idx_s = IDXW'(a_q);
        cap_vld_s = 1'b1; cap_idx_s = IDXW'(NREG);
      end
      S2: begin
        drv_vld_s = 1'b1; drv_idx_s = IDXW'(b_q);
        cap_vld_s = 1'b1; cap_idx_s = IDXW'(a_q);
      end
      S3: begin
        drv_vld_s = 1'b1; drv_idx_s = IDXW'(NREG);
        cap_vld_s = 1'b1; cap_idx_s = IDXW'(b_q);
        done_s    = 1'b1;
      end
      CP: begin
        drv_vld_s = 1'b1; drv_idx_s = IDXW'(a_q);
        cap_vld_s = 1'b1; cap_idx_s = IDXW'(b_q);
        done_s    = 1'b1;
      end
      default: begin
        drv_vld_s = 1'b0;
        cap_vld_s = 1'b0;
      end
    endcase
  end

  // One-hot expansion of the bus controls and the bus mux itself
  always_comb begin
    rout_s = {(NREG+1){1'b0}};
    rin_s  = {(NREG+1){1'b0}};
    for (int i = 0; i <= NREG; i++) begin
      rout_s[i] = drv_vld_s && (drv_idx_s == IDXW'(i));
      rin_s[i]  = cap_vld_s && (cap_idx_s == IDXW'(i));
    end
    if (drv_vld_s) begin
      bus_s = regs_q[drv_idx_s];
    end else begin
      bus_s = {WIDTH{1'b0}};
    end
  end

  // Register file: bus capture while sequencing, external load only from IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= NREG; i++) regs_q[i] <= {WIDTH{1'b0}};
    end else begin
      for (int i = 0; i <= NREG; i++) begin
        if (rin_s[i]) begin
          regs_q[i] <= bus_s;
        end else if (ld_en_s && (i < NREG) && (int'(ld_sel) == i)) begin
          regs_q[i] <= data_in;
        end else begin
          regs_q[i] <= regs_q[i];
        end
      end
    end
  end

`ifdef REG_SWAP_CNT_EN
  logic [15:0] cnt_q;

  // Completed-operation counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else if (done_s) begin
      cnt_q <= cnt_q + 16'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign op_cnt = cnt_q;
`endif

  assign rd_data = (int'(rd_sel) < NREG) ? regs_q[IDXW'(rd_sel)] : {WIDTH{1'b0}};
  assign rout    = rout_s;
  assign rin     = rin_s;
  assign bus     = bus_s;
  assign busy    = (state_q != IDLE);
  assign Done    = done_s;
  assign err     = err_q;

endmodule

// File: tb/tb_reg_swap_ctrl.sv
// Directed self-checking bench for reg_swap_ctrl (NREG=4 main instance, NREG=3 for
// out-of-range selects). Counter scenario compiled only with REG_SWAP_CNT_EN.
module tb_reg_swap_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       w = 1'b0, mode = 1'b0, ld = 1'b0;
  logic [1:0] sel_a = 2'd0, sel_b = 2'd0, ld_sel = 2'd0, rd_sel = 2'd0;
  logic [7:0] data_in = 8'd0;
  logic [7:0] rd_data, bus;
  logic [4:0] rout, rin;
  logic       busy, done, err;

  logic       w3 = 1'b0, ld3 = 1'b0;
  logic [1:0] sel_a3 = 2'd0, sel_b3 = 2'd0, ld_sel3 = 2'd0, rd_sel3 = 2'd0;
  logic [7:0] data_in3 = 8'd0;
  logic [7:0] rd_data3, bus3;
  logic [3:0] rout3, rin3;
  logic       busy3, done3, err3;
`ifdef REG_SWAP_CNT_EN
  logic [15:0] op_cnt, op_cnt3;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_swap_ctrl #(.WIDTH(8), .NREG(4), .SELW(2)) u_dut (
    .clk(clk), .reset(reset), .w(w), .mode(mode), .sel_a(sel_a), .sel_b(sel_b),
    .ld(ld), .ld_sel(ld_sel), .data_in(data_in), .rd_sel(rd_sel), .rd_data(rd_data),
    .rout(rout), .rin(rin), .bus(bus), .busy(busy), .Done(done),
`ifdef REG_SWAP_CNT_EN
    .op_cnt(op_cnt),
`endif
    .err(err)
  );

  reg_swap_ctrl #(.WIDTH(8), .NREG(3), .SELW(2)) u_dut3 (
    .clk(clk), .reset(reset), .w(w3), .mode(1'b0), .sel_a(sel_a3), .sel_b(sel_b3),
    .ld(ld3), .ld_sel(ld_sel3), .data_in(data_in3), .rd_sel(rd_sel3), .rd_data(rd_data3),
    .rout(rout3), .rin(rin3), .bus(bus3), .busy(busy3), .Done(done3),
`ifdef REG_SWAP_CNT_EN
    .op_cnt(op_cnt3),
`endif
    .err(err3)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [1:0] idx, input logic [7:0] val);
    ld = 1'b1; ld_sel = idx; data_in = val;
    step();
    ld = 1'b0;
  endtask

  task automatic chk_rd(input logic [1:0] idx, input logic [7:0] exp, input string nm);
    rd_sel = idx;
    #1;
    total++;
    if (rd_data !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, rd_data, exp);
    end
  endtask

  task automatic chk_ctl(input logic [4:0] ero, input logic [4:0] eri, input logic [7:0] eb,
                         input logic eby, input logic ed, input string nm);
    total++;
    if (rout !== ero || rin !== eri || bus !== eb || busy !== eby || done !== ed) begin
      bad++;
      $display("FAIL %s got rout=%b rin=%b bus=%h busy=%b done=%b exp %b %b %h %b %b",
               nm, rout, rin, bus, busy, done, ero, eri, eb, eby, ed);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_ctl(5'b00000, 5'b00000, 8'h00, 1'b0, 1'b0, "reset_ctl");
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    chk_rd(2'd0, 8'h00, "reset_r0");
    chk_rd(2'd3, 8'h00, "reset_r3");
  endtask

  task automatic test_swap();
    load(2'd0, 8'hA5);
    load(2'd1, 8'h3C);
    chk_rd(2'd0, 8'hA5, "load_r0");
    chk_rd(2'd1, 8'h3C, "load_r1");
    w = 1'b1; mode = 1'b0; sel_a = 2'd0; sel_b = 2'd1;
    step();
    w = 1'b0;
    chk_ctl(5'b00001, 5'b10000, 8'hA5, 1'b1, 1'b0, "swap_s1");
    step();
    chk_ctl(5'b00010, 5'b00001, 8'h3C, 1'b1, 1'b0, "swap_s2");
    step();
    chk_ctl(5'b10000, 5'b00010, 8'hA5, 1'b1, 1'b1, "swap_s3");
    step();
    chk_ctl(5'b00000, 5'b00000, 8'h00, 1'b0, 1'b0, "swap_idle");
    chk_rd(2'd0, 8'h3C, "swap_r0");
    chk_rd(2'd1, 8'hA5, "swap_r1");
  endtask

  task automatic test_copy();
    load(2'd2, 8'h77);
    w = 1'b1; mode = 1'b1; sel_a = 2'd2; sel_b = 2'd3;
    step();
    w = 1'b0; mode = 1'b0;
    chk_ctl(5'b00100, 5'b01000, 8'h77, 1'b1, 1'b1, "copy_cp");
    step();
    chk_ctl(5'b00000, 5'b00000, 8'h00, 1'b0, 1'b0, "copy_idle");
    chk_rd(2'd3, 8'h77, "copy_r3");
    chk_rd(2'd2, 8'h77, "copy_r2");
  endtask

  task automatic test_reject();
    ld3 = 1'b1; ld_sel3 = 2'd0; data_in3 = 8'h11; step();
    ld_sel3 = 2'd2; data_in3 = 8'h33; step();
    ld_sel3 = 2'd3; data_in3 = 8'h99; step();
    ld3 = 1'b0;
    total++;
    if (err3 !== 1'b1) begin bad++; $display("FAIL ld_oor_err got=%b exp=1", err3); end
    w3 = 1'b1; sel_a3 = 2'd0; sel_b3 = 2'd3;
    step();
    w3 = 1'b0;
    total++;
    if (err3 !== 1'b1 || busy3 !== 1'b0) begin
      bad++; $display("FAIL sel_oor got err=%b busy=%b exp err=1 busy=0", err3, busy3);
    end
    step();
    total++;
    if (err3 !== 1'b0 || busy3 !== 1'b0) begin
      bad++; $display("FAIL err_pulse got err=%b busy=%b exp 0 0", err3, busy3);
    end
    rd_sel3 = 2'd0; #1;
    total++;
    if (rd_data3 !== 8'h11) begin bad++; $display("FAIL oor_r0 got=%h exp=11", rd_data3); end
    rd_sel3 = 2'd2; #1;
    total++;
    if (rd_data3 !== 8'h33) begin bad++; $display("FAIL oor_r2 got=%h exp=33", rd_data3); end
    rd_sel3 = 2'd3; #1;
    total++;
    if (rd_data3 !== 8'h00) begin bad++; $display("FAIL rd_oor got=%h exp=00", rd_data3); end
  endtask

  task automatic test_ld_ignored();
    // r0=3C r1=A5 r2=77 r3=77; swap r1<->r2 with a load attempt mid-sequence
    w = 1'b1; mode = 1'b0; sel_a = 2'd1; sel_b = 2'd2;
    step();
    w = 1'b0;
    ld = 1'b1; ld_sel = 2'd0; data_in = 8'hFF;
    step();
    ld = 1'b0;
    step();
    step();
    chk_rd(2'd0, 8'h3C, "midswap_ld_r0");
    chk_rd(2'd1, 8'h77, "midswap_r1");
    chk_rd(2'd2, 8'hA5, "midswap_r2");
    // ld together with w: copy r0->r3 runs, load to r1 dropped
    w = 1'b1; mode = 1'b1; sel_a = 2'd0; sel_b = 2'd3;
    ld = 1'b1; ld_sel = 2'd1; data_in = 8'hEE;
    step();
    w = 1'b0; ld = 1'b0; mode = 1'b0;
    chk_ctl(5'b00001, 5'b01000, 8'h3C, 1'b1, 1'b1, "ldw_cp");
    step();
    chk_rd(2'd3, 8'h3C, "ldw_r3");
    chk_rd(2'd1, 8'h77, "ldw_r1_kept");
  endtask

  task automatic test_reset_abort();
    w = 1'b1; mode = 1'b0; sel_a = 2'd0; sel_b = 2'd2;
    step();
    w = 1'b0;
    step();
    chk_ctl(5'b00100, 5'b00001, 8'hA5, 1'b1, 1'b0, "abort_in_s2");
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_ctl(5'b00000, 5'b00000, 8'h00, 1'b0, 1'b0, "abort_ctl");
    chk_rd(2'd0, 8'h00, "abort_r0");
    chk_rd(2'd1, 8'h00, "abort_r1");
    chk_rd(2'd2, 8'h00, "abort_r2");
    chk_rd(2'd3, 8'h00, "abort_r3");
    step();
    chk_ctl(5'b00000, 5'b00000, 8'h00, 1'b0, 1'b0, "abort_stays_idle");
  endtask

`ifdef REG_SWAP_CNT_EN
  task automatic test_counter();
    force u_dut.cnt_q = 16'hFFFE;
    #1;
    release u_dut.cnt_q;
    w = 1'b1; mode = 1'b1; sel_a = 2'd0; sel_b = 2'd1;
    step();
    w = 1'b0;
    step();
    total++;
    if (op_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_ffff got=%h exp=ffff", op_cnt); end
    w = 1'b1;
    step();
    w = 1'b0;
    step();
    total++;
    if (op_cnt !== 16'h0000) begin bad++; $display("FAIL cnt_wrap got=%h exp=0000", op_cnt); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_swap();
    test_copy();
    test_reject();
    test_ld_ignored();
    test_reset_abort();
`ifdef REG_SWAP_CNT_EN
    test_counter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
